// File: rtl/drum_mult_scale.sv
// drum_mult_scale: back end of the DRUM approximate multiplier.
// Multiplies two K-bit truncated operands with a shift-add loop, then
// rescales the 2K-bit product by the summed operand shifts into 2*N bits.
module drum_mult_scale #(
    parameter int K  = 4,
    parameter int SW = 3,
    parameter int N  = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [K-1:0]   a_trunc,
    input  logic [SW-1:0]  a_shift,
    input  logic [K-1:0]   b_trunc,
    input  logic [SW-1:0]  b_shift,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] result,
    output logic           busy
);

    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MULT  = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [K-1:0]    a_val;       // multiplicand
    logic [K-1:0]    b_val;       // multiplier, scanned bit by bit
    logic [SW:0]     shift_sum;   // one extra bit so the sum of two shifts never wraps
    logic [2*K-1:0]  acc;
    logic [CW-1:0]   cnt;

    logic [2*K-1:0]  mcand_ext;
    logic [2*N-1:0]  acc_ext;

    assign mcand_ext = {{K{1'b0}}, a_val};
    assign acc_ext   = {{(2*N-2*K){1'b0}}, acc};

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: MULT runs for exactly K edges before SCALE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = MULT;
            MULT:    if (cnt == CW'(K-1)) state_nxt = SCALE;
            SCALE:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add accumulation, rescale and output hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_val     <= '0;
            b_val     <= '0;
            shift_sum <= '0;
            acc       <= '0;
            cnt       <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_val     <= a_trunc;
                        b_val     <= b_trunc;
                        shift_sum <= {1'b0, a_shift} + {1'b0, b_shift};
                        acc       <= '0;
                        cnt       <= '0;
                    end
                end
                MULT: begin
                    if (b_val[cnt]) begin
                        acc <= acc + (mcand_ext << cnt);
                    end
                    cnt <= cnt + 1'b1;
                end
                SCALE: begin
                    // Shifts beyond the legal range simply fall off the top.
                    result    <= acc_ext << shift_sum;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_drum_mult_scale.sv
// Testbench for drum_mult_scale: directed vector table plus handshake,
// backpressure and mid-operation reset sequences.
module tb_drum_mult_scale;

    localparam int K  = 4;
    localparam int SW = 3;
    localparam int N  = 8;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [K-1:0]   a_trunc;
    logic [SW-1:0]  a_shift;
    logic [K-1:0]   b_trunc;
    logic [SW-1:0]  b_shift;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] result;
    logic           busy;

    int total;
    int bad;

    typedef struct {
        int a;
        int as;
        int b;
        int bs;
        int exp;
    } vec_t;

    vec_t vecs[8];

    drum_mult_scale #(.K(K), .SW(SW), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_trunc   (a_trunc),
        .a_shift   (a_shift),
        .b_trunc   (b_trunc),
        .b_shift   (b_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int a, input int as, input int b, input int bs);
        a_trunc = K'(a);
        a_shift = SW'(as);
        b_trunc = K'(b);
        b_shift = SW'(bs);
    endtask

    // After the accept edge (called at the following negedge), count edges
    // until out_valid, then check latency and result.
    task automatic wait_result(input string name, input int exp);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk({name, " latency"}, n, K + 1);
        chk({name, " result"}, int'(result), exp);
    endtask

    // Full transaction with immediate drain.
    task automatic run_op(input string name, input int a, input int as,
                          input int b, input int bs, input int exp);
        @(negedge clk);
        chk({name, " in_ready before"}, int'(in_ready), 1);
        drive(a, as, b, bs);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk({name, " busy"}, int'(busy), 1);
        wait_result(name, exp);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, " out_valid drop"}, int'(out_valid), 0);
        chk({name, " result kept"}, int'(result), exp);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        drive(0, 0, 0, 0);

        vecs[0] = '{a: 13, as: 4, b: 13, bs: 3, exp: 21632};
        vecs[1] = '{a: 5,  as: 0, b: 3,  bs: 0, exp: 15};
        vecs[2] = '{a: 0,  as: 4, b: 15, bs: 4, exp: 0};
        vecs[3] = '{a: 15, as: 4, b: 15, bs: 4, exp: 57600};
        vecs[4] = '{a: 1,  as: 0, b: 1,  bs: 0, exp: 1};
        vecs[5] = '{a: 9,  as: 1, b: 11, bs: 2, exp: 792};
        vecs[6] = '{a: 13, as: 0, b: 13, bs: 0, exp: 169};
        vecs[7] = '{a: 15, as: 7, b: 15, bs: 7, exp: 16384};

        // Reset values, before any clock edge.
        #2;
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset result", int'(result), 0);
        chk("reset busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].as,
                   vecs[i].b, vecs[i].bs, vecs[i].exp);
        end

        // Backpressure: hold out_ready low, offer a second op meanwhile.
        @(negedge clk);
        drive(13, 4, 13, 3);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive(5, 0, 3, 0);
        wait_result("bp", 21632);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp result stable", int'(result), 21632);
            chk("bp out_valid held", int'(out_valid), 1);
            chk("bp in_ready low", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp out_valid drop", int'(out_valid), 0);
        chk("bp in_ready back", int'(in_ready), 1);
        chk("bp second not taken", int'(busy), 0);
        // Second op, held on in_valid all along, is accepted now.
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp second accepted", int'(busy), 1);
        wait_result("bp second", 15);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp second drop", int'(out_valid), 0);

        // Reset during MULT discards the operation.
        drive(15, 4, 15, 4);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst in_ready", int'(in_ready), 1);
        chk("midrst busy", int'(busy), 0);
        chk("midrst out_valid", int'(out_valid), 0);
        chk("midrst result", int'(result), 0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("midrst no output", seen, 0);
        end
        run_op("post rst", 7, 0, 9, 1, 126);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
